// File: rtl/conv_fmap_streamer.sv
// conv_fmap_streamer: buffers one I_SIZE x I_SIZE feature map and replays it
// in raster order once per output channel into a streaming convolution engine.
// Ports: write side  i_wr_en, i_wr_data -> o_wr_ready, o_fmap_full
//        control     i_start, i_conv_end -> o_busy, o_done, o_error, o_ch_idx
//        engine side o_ce, o_fmap, o_self_rst
//        clocking    clk, global_rst_n (async, low), rst (sync, high)
module conv_fmap_streamer #(
    parameter int I_BW      = 8,
    parameter int I_SIZE    = 12,
    parameter int K_SIZE    = 5,
    parameter int CO        = 4,
    parameter int FLUSH_MAX = 8
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [I_BW-1:0]       i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_fmap_full,
    input  logic                  i_start,
    input  logic                  i_conv_end,
    output logic                  o_ce,
    output logic [I_BW-1:0]       o_fmap,
    output logic                  o_self_rst,
    output logic [$clog2(CO):0]   o_ch_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int N  = I_SIZE * I_SIZE;
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(CO) + 1;
    localparam int PW = $clog2(FLUSH_MAX + 1);

    localparam logic [AW-1:0] LAST     = AW'(N - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CO - 1);
    localparam logic [PW-1:0] PAD_LAST = PW'(FLUSH_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_STREAM, S_FLUSH, S_CHRST, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [I_BW-1:0] r_mem [N];
    logic [I_BW-1:0] r_rd_data;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_p;
    logic [AW-1:0]   w_rd_addr;
    logic [PW-1:0]   r_pad;
    logic [CW-1:0]   r_ch;
    logic            r_full;
    logic            r_err;
    logic            w_wr_acc;
    logic            w_pad_to;

    assign w_wr_acc = i_wr_en && !r_full;
    assign w_pad_to = (r_pad == PAD_LAST);

    // READ primes address 0; STREAM prefetches p+1 so data lines up with o_ce.
    assign w_rd_addr = (r_state == S_STREAM && r_p != LAST) ?
                       r_p + AW'(1) : '0;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_start && r_full) w_next = S_READ;
            S_READ:   w_next = S_STREAM;
            S_STREAM: if (r_p == LAST) w_next = S_FLUSH;
            S_FLUSH:  if (i_conv_end || w_pad_to) w_next = S_CHRST;
            S_CHRST:  w_next = (r_ch == CH_LAST) ? S_DONE : S_READ;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_state   <= S_IDLE;
            r_wr_addr <= '0;
            r_p       <= '0;
            r_pad     <= '0;
            r_ch      <= '0;
            r_full    <= 1'b0;
            r_err     <= 1'b0;
        end else if (rst) begin
            r_state   <= S_IDLE;
            r_wr_addr <= '0;
            r_p       <= '0;
            r_pad     <= '0;
            r_ch      <= '0;
            r_full    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wr_acc) begin
                if (r_wr_addr == LAST) begin
                    r_wr_addr <= '0;
                    r_full    <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + AW'(1);
                end
            end
            if (r_state == S_DONE) r_full <= 1'b0;
            r_p   <= (r_state == S_STREAM) ? r_p + AW'(1) : '0;
            r_pad <= (r_state == S_FLUSH) ? r_pad + PW'(1) : '0;
            // A conv_end in the last pad cycle still counts as a clean finish.
            if (r_state == S_FLUSH && w_pad_to && !i_conv_end)
                r_err <= 1'b1;
            if (r_state == S_CHRST) r_ch <= r_ch + CW'(1);
            if (r_state == S_DONE)  r_ch <= '0;
        end
    end

    // Plain RAM: contents need no reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_addr] <= i_wr_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    assign o_ce        = (r_state == S_STREAM) || (r_state == S_FLUSH);
    assign o_fmap      = (r_state == S_STREAM) ? r_rd_data : '0;
    assign o_self_rst  = (r_state == S_CHRST);
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_ch_idx    = r_ch;
    assign o_error     = r_err;
    assign o_fmap_full = r_full;
    assign o_wr_ready  = !r_full;

    a_ce_rst_excl: assert property (@(posedge clk) disable iff (!global_rst_n)
        !(o_ce && o_self_rst));
    a_kernel_fits: assert property (@(posedge clk) disable iff (!global_rst_n)
        o_ce |-> (K_SIZE <= I_SIZE));
endmodule

// File: tb/tb_conv_fmap_streamer.sv
// tb_conv_fmap_streamer: directed test of conv_fmap_streamer with a 6x6 map,
// two channels and FLUSH_MAX=8; expected values are computed in the bench.
module tb_conv_fmap_streamer;
    localparam int NPIX = 36;
    localparam int FMAX = 8;

    logic       clk = 1'b0;
    logic       global_rst_n = 1'b0;
    logic       rst = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = '0;
    logic       o_wr_ready;
    logic       o_fmap_full;
    logic       i_start = 1'b0;
    logic       i_conv_end = 1'b0;
    logic       o_ce;
    logic [7:0] o_fmap;
    logic       o_self_rst;
    logic [1:0] o_ch_idx;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    int n_chk = 0;
    int n_fail = 0;
    int exp_px [NPIX];

    conv_fmap_streamer #(
        .I_BW(8), .I_SIZE(6), .K_SIZE(5), .CO(2), .FLUSH_MAX(FMAX)
    ) dut (
        .clk(clk), .global_rst_n(global_rst_n), .rst(rst),
        .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
        .o_wr_ready(o_wr_ready), .o_fmap_full(o_fmap_full),
        .i_start(i_start), .i_conv_end(i_conv_end),
        .o_ce(o_ce), .o_fmap(o_fmap), .o_self_rst(o_self_rst),
        .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic load(input int mul, input int off);
        for (int i = 0; i < NPIX; i++) begin
            exp_px[i] = i * mul + off;
            i_wr_en   = 1'b1;
            i_wr_data = 8'(exp_px[i]);
            tick();
            chk("load_full", o_fmap_full, (i == NPIX - 1));
        end
        i_wr_en = 1'b0;
    endtask

    task automatic start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("read_ce", o_ce, 0);
        chk("read_busy", o_busy, 1);
        tick();
    endtask

    // Called in the first STREAM cycle; returns in the CHRST cycle.
    task automatic run_channel(input int endpad, input int prem,
                               input logic exp_err);
        for (int p = 0; p < NPIX; p++) begin
            chk("stream_ce", o_ce, 1);
            chk("stream_px", $signed(o_fmap), exp_px[p]);
            i_conv_end = (p == prem);
            tick();
        end
        i_conv_end = 1'b0;
        for (int k = 1; k <= FMAX; k++) begin
            chk("flush_ce", o_ce, 1);
            chk("flush_px", $signed(o_fmap), 0);
            chk("flush_srst", o_self_rst, 0);
            i_conv_end = (k == endpad);
            tick();
            i_conv_end = 1'b0;
            if (k == endpad) break;
        end
        chk("chrst_srst", o_self_rst, 1);
        chk("chrst_ce", o_ce, 0);
        chk("chrst_px", $signed(o_fmap), 0);
        chk("chrst_err", o_error, exp_err);
    endtask

    task automatic next_channel(input int ch);
        tick();
        chk("nxt_srst", o_self_rst, 0);
        chk("nxt_ch", o_ch_idx, ch);
        chk("nxt_ce", o_ce, 0);
        chk("nxt_busy", o_busy, 1);
        tick();
    endtask

    task automatic finish_seq();
        tick();
        chk("done_pulse", o_done, 1);
        chk("done_busy", o_busy, 0);
        chk("done_ce", o_ce, 0);
        tick();
        chk("idle_done", o_done, 0);
        chk("idle_ch", o_ch_idx, 0);
        chk("idle_full", o_fmap_full, 0);
        chk("idle_wrrdy", o_wr_ready, 1);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_wrrdy", o_wr_ready, 1);
        chk("rst_full", o_fmap_full, 0);
        chk("rst_ce", o_ce, 0);
        chk("rst_fmap", o_fmap, 0);
        chk("rst_srst", o_self_rst, 0);
        chk("rst_ch", o_ch_idx, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_error, 0);
        global_rst_n = 1'b1;
        tick();

        // Start with an empty buffer is ignored
        i_start = 1'b1;
        tick();
        tick();
        tick();
        chk("nostart_ce", o_ce, 0);
        chk("nostart_busy", o_busy, 0);
        i_start = 1'b0;

        // Fill 0..35, then an extra write that must be dropped
        load(1, 0);
        chk("full_wrrdy", o_wr_ready, 0);
        i_wr_en   = 1'b1;
        i_wr_data = 8'd99;
        tick();
        i_wr_en = 1'b0;
        chk("extra_full", o_fmap_full, 1);

        // Two clean replays, conv_end after 3 pad cycles
        start();
        run_channel(3, -1, 1'b0);
        next_channel(1);
        run_channel(3, -1, 1'b0);
        finish_seq();

        // Timeout on ch0 with premature conv_end; ch1 ends after 2 pads
        load(3, -50);
        start();
        run_channel(0, 10, 1'b1);
        next_channel(1);
        run_channel(2, -1, 1'b1);
        finish_seq();
        chk("err_sticky", o_error, 1);

        // Synchronous reset in the middle of channel 1
        load(-2, 40);
        start();
        run_channel(1, -1, 1'b1);
        next_channel(1);
        for (int p = 0; p < 5; p++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ce", o_ce, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_full", o_fmap_full, 0);
        chk("abort_ch", o_ch_idx, 0);
        chk("abort_err", o_error, 0);
        chk("abort_wrrdy", o_wr_ready, 1);

        // Fresh load replays from channel 0
        load(5, -90);
        start();
        chk("fresh_ch", o_ch_idx, 0);
        run_channel(4, -1, 1'b0);
        next_channel(1);
        run_channel(1, -1, 1'b0);
        finish_seq();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
